mem_port_arbiter: RTL and testbench

Sequential arbiter sharing one single-ported memory between the IF stage (instruction fetch) and the MEM stage (lw/sw, driven by the decoded MemRead/MemWrite controls) of the 5-stage RISC-V pipeline. Sits between the pipeline and the unified memory. Serialises accesses through a request/done handshake and raises per-stage stall signals until each access completes. Data accesses normally win; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage.
// Data accesses win by default; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_done_i
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StIfWait = 2'd1;
    localparam logic [1:0] StDmWait = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic dm_req;
    logic grant_if;
    logic grant_dm;

    assign dm_req = dm_read_i | dm_write_i;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_data_d    = if_data_q;
        dm_rdata_d   = dm_rdata_q;
        grant_if     = 1'b0;
        grant_dm     = 1'b0;

        case (state_q)
            StIdle: begin
                grant_if = if_req_i && (!dm_req || (starve_cnt_q == StarveMax));
                grant_dm = dm_req && !grant_if;
                if (grant_if) begin
                    state_d      = StIfWait;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr_i;
                    starve_cnt_d = '0;
                end else if (grant_dm) begin
                    state_d     = StDmWait;
                    mem_req_d   = 1'b1;
                    // Read and write together resolve to a write.
                    mem_we_d    = dm_write_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    if (!if_req_i) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != StarveMax) begin
                        starve_cnt_d = starve_cnt_q + CntW'(1);
                    end
                end else if (!if_req_i) begin
                    starve_cnt_d = '0;
                end
            end
            StIfWait: begin
                if (mem_done_i) begin
                    if_data_d = mem_rdata_i;
                    if_ack_d  = 1'b1;
                    state_d   = StResp;
                end
            end
            StDmWait: begin
                if (mem_done_i) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                    dm_ack_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_data_q    <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_data_q    <= if_data_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;

    assign stall_if_o  = if_req_i & ~if_ack_q;
    assign stall_mem_o = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-programmable memory responder plus requester tasks,
// checked against a word-level reference memory and a grant-order model.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        stall_if_o;
    logic        stall_mem_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_done_i  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    logic [31:0] phys    [64];
    logic [31:0] ref_mem [64];

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;
    grant_t glog[$];

    bit          mem_manual = 1'b0;
    bit          rand_lat   = 1'b0;
    int          mem_lat    = 0;
    bit          busy       = 1'b0;
    bit          prev_req   = 1'b0;
    int          lat_cnt    = 0;
    logic [31:0] sa;
    logic        swe;
    logic [31:0] swd;
    grant_t      g;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_data_o  (if_data_o),
        .if_ack_o   (if_ack_o),
        .dm_read_i  (dm_read_i),
        .dm_write_i (dm_write_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_rdata_o (dm_rdata_o),
        .dm_ack_o   (dm_ack_o),
        .stall_if_o (stall_if_o),
        .stall_mem_o(stall_mem_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_done_i (mem_done_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Memory device: completes each access mem_lat cycles after its mem_req_o cycle.
    always @(negedge clk) begin
        if (mem_manual) begin
            busy     = 1'b0;
            prev_req = 1'b0;
        end else begin
            mem_done_i = 1'b0;
            if (mem_req_o) begin
                n_tests++;
                if (prev_req || busy) begin
                    n_fail++;
                    $display("FAIL mem_req_overlap: got mem_req_o=1 with access open, want 0");
                end
                g.cyc = cyc_cnt; g.addr = mem_addr_o; g.we = mem_we_o; g.wdata = mem_wdata_o;
                glog.push_back(g);
                sa = mem_addr_o; swe = mem_we_o; swd = mem_wdata_o;
                lat_cnt = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                busy = 1'b1;
            end else if (busy) begin
                n_tests++;
                if (mem_addr_o !== sa || mem_we_o !== swe || mem_wdata_o !== swd) begin
                    n_fail++;
                    $display("FAIL access_hold: got addr=%h we=%b wd=%h, want addr=%h we=%b wd=%h",
                             mem_addr_o, mem_we_o, mem_wdata_o, sa, swe, swd);
                end
            end
            if (busy) begin
                if (lat_cnt == 0) begin
                    if (swe) begin
                        phys[sa[7:2]] = swd;
                        mem_rdata_i = $urandom;
                    end else begin
                        mem_rdata_i = phys[sa[7:2]];
                    end
                    mem_done_i = 1'b1;
                    busy = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            prev_req = mem_req_o;
        end
    end

    function automatic bit is_fetch(input logic [31:0] a);
        return a < 32'h80;
    endfunction

    task automatic fetch_op(input logic [31:0] a, input bit hold, output logic [31:0] d,
                            output int waits, output int req_cyc);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if_req_i = 1'b1; if_addr_i = a; req_cyc = cyc_cnt; waits = 0; d = '0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            n_tests++;
            if (if_ack_o) begin
                got = 1'b1; d = if_data_o;
                if (stall_if_o !== 1'b0) begin
                    n_fail++; $display("FAIL stall_if_ack: got %b, want 0", stall_if_o);
                end
            end else begin
                waits++;
                if (stall_if_o !== 1'b1) begin
                    n_fail++; $display("FAIL stall_if_wait: got %b, want 1", stall_if_o);
                end
            end
        end
        if (!got) begin
            n_tests++; n_fail++; $display("FAIL fetch_timeout: got no if_ack_o, want one");
        end
        if (!hold) begin
            @(posedge clk); #1; if_req_i = 1'b0;
        end
    endtask

    task automatic data_op(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input bit hold,
                           output logic [31:0] rdata, output int waits);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        dm_read_i = rd; dm_write_i = wr; dm_addr_i = a; dm_wdata_i = wd; waits = 0; rdata = '0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            n_tests++;
            if (dm_ack_o) begin
                got = 1'b1; rdata = dm_rdata_o;
                if (stall_mem_o !== 1'b0) begin
                    n_fail++; $display("FAIL stall_mem_ack: got %b, want 0", stall_mem_o);
                end
            end else begin
                waits++;
                if (stall_mem_o !== 1'b1) begin
                    n_fail++; $display("FAIL stall_mem_wait: got %b, want 1", stall_mem_o);
                end
            end
        end
        if (!got) begin
            n_tests++; n_fail++; $display("FAIL data_timeout: got no dm_ack_o, want one");
        end
        if (!hold) begin
            @(posedge clk); #1; dm_read_i = 1'b0; dm_write_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; dm_read_i = 1'b0; dm_write_i = 1'b0;
        dm_addr_i = '0; dm_wdata_i = '0;
        #2 rst_i = 1'b1;
        #2;
        n_tests++;
        if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, want 0000",
                               {mem_req_o, mem_we_o, if_ack_o, dm_ack_o});
        end
        n_tests++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h/%h, want 0/0", mem_addr_o, mem_wdata_o);
        end
        n_tests++;
        if (if_data_o !== 32'h0 || dm_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h, want 0/0", if_data_o, dm_rdata_o);
        end
        n_tests++;
        if (stall_if_o !== 1'b0 || stall_mem_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b%b, want 00", stall_if_o, stall_mem_o);
        end
        if_req_i = 1'b1; dm_write_i = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold_req: got %b, want 0", mem_req_o);
        end
        n_tests++;
        if (stall_if_o !== 1'b1 || stall_mem_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_stall_comb: got %b%b, want 11", stall_if_o, stall_mem_o);
        end
        if_req_i = 1'b0; dm_write_i = 1'b0;
        @(negedge clk); rst_i = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] d;
        int w, rc;
        phys[0] = 32'h0050_0093; ref_mem[0] = 32'h0050_0093;
        rand_lat = 1'b0; mem_lat = 0;
        fetch_op(32'h0, 1'b0, d, w, rc);
        n_tests++;
        if (d !== 32'h0050_0093) begin
            n_fail++; $display("FAIL fetch_data: got %h, want 00500093", d);
        end
        n_tests++;
        if (w != 2) begin
            n_fail++; $display("FAIL fetch_latency: got %0d stall cycles, want 2", w);
        end
    endtask

    task automatic test_load_store();
        logic [31:0] d;
        int w;
        bit got;
        phys[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
        rand_lat = 1'b0; mem_lat = 3; got = 1'b0;
        @(posedge clk); #1;
        dm_read_i = 1'b1; dm_addr_i = 32'h40; dm_wdata_i = $urandom;
        for (int c = 0; c < 16 && !got; c++) begin
            @(negedge clk);
            if (mem_req_o) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL lw_issue: got no mem_req_o, want one");
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if (mem_addr_o !== 32'h40 || mem_we_o !== 1'b0 || dm_ack_o !== 1'b0) begin
                n_fail++; $display("FAIL lw_hold[%0d]: got addr=%h we=%b ack=%b, want 40/0/0",
                                   i, mem_addr_o, mem_we_o, dm_ack_o);
            end
        end
        @(negedge clk);
        n_tests++;
        if (dm_ack_o !== 1'b1 || dm_rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL lw_ack: got ack=%b data=%h, want 1/deadbeef",
                               dm_ack_o, dm_rdata_o);
        end
        @(posedge clk); #1; dm_read_i = 1'b0;
        mem_lat = 1;
        data_op(1'b0, 1'b1, 32'h44, 32'h1234_5678, 1'b0, d, w);
        ref_mem[17] = 32'h1234_5678;
        n_tests++;
        if (glog[$].we !== 1'b1 || glog[$].wdata !== 32'h1234_5678 || glog[$].addr !== 32'h44)
        begin
            n_fail++; $display("FAIL sw_issue: got we=%b wd=%h addr=%h, want 1/12345678/44",
                               glog[$].we, glog[$].wdata, glog[$].addr);
        end
        n_tests++;
        if (d !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_rdata_hold: got %h, want deadbeef", d);
        end
    endtask

    task automatic test_read_write_both();
        logic [31:0] d;
        int w;
        rand_lat = 1'b0; mem_lat = 0;
        data_op(1'b1, 1'b1, 32'h90, 32'hCAFE_F00D, 1'b0, d, w);
        ref_mem[36] = 32'hCAFE_F00D;
        n_tests++;
        if (glog[$].we !== 1'b1 || glog[$].wdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL both_as_write: got we=%b wd=%h, want 1/cafef00d",
                               glog[$].we, glog[$].wdata);
        end
        n_tests++;
        if (d !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL both_rdata_hold: got %h, want deadbeef", d);
        end
    endtask

    task automatic test_simultaneous();
        int dm_ack_c, if_req_c, if_ack_c, nreq;
        logic [31:0] first_addr, dd, fd;
        rand_lat = 1'b0; mem_lat = 0;
        dm_ack_c = -1; if_req_c = -1; if_ack_c = -1; nreq = 0; first_addr = '0;
        dd = '0; fd = '0;
        @(posedge clk); #1;
        if_req_i = 1'b1; if_addr_i = 32'h08; dm_read_i = 1'b1; dm_addr_i = 32'h84;
        for (int c = 1; c <= 40 && if_ack_c < 0; c++) begin
            @(negedge clk);
            if (mem_req_o) begin
                nreq++;
                if (nreq == 1) first_addr = mem_addr_o;
                else if (mem_addr_o == 32'h08) if_req_c = c;
            end
            if (if_ack_o) begin
                if_ack_c = c; fd = if_data_o;
            end else begin
                n_tests++;
                if (stall_if_o !== 1'b1) begin
                    n_fail++; $display("FAIL sim_stall_if: got %b at cycle %0d, want 1",
                                       stall_if_o, c);
                end
            end
            if (dm_ack_o) begin
                dm_ack_c = c; dd = dm_rdata_o;
                @(posedge clk); #1; dm_read_i = 1'b0;
            end
        end
        @(posedge clk); #1; if_req_i = 1'b0;
        n_tests++;
        if (first_addr !== 32'h84) begin
            n_fail++; $display("FAIL sim_dm_first: got %h, want 84", first_addr);
        end
        n_tests++;
        if (dm_ack_c < 0 || if_req_c != dm_ack_c + 2) begin
            n_fail++; $display("FAIL sim_if_next: got if grant cycle %0d, want %0d",
                               if_req_c, dm_ack_c + 2);
        end
        n_tests++;
        if (if_ack_c < 0 || fd !== ref_mem[2] || dd !== ref_mem[33]) begin
            n_fail++; $display("FAIL sim_data: got if=%h dm=%h, want %h/%h",
                               fd, dd, ref_mem[2], ref_mem[33]);
        end
    endtask

    task automatic test_starvation();
        int log0;
        bit f_done;
        string pat;
        rand_lat = 1'b0; mem_lat = 1;
        log0 = glog.size(); f_done = 1'b0;
        fork
            begin
                logic [31:0] d;
                int w, rc;
                fetch_op(32'h10, 1'b1, d, w, rc);
                fetch_op(32'h14, 1'b0, d, w, rc);
                f_done = 1'b1;
            end
            begin
                logic [31:0] d;
                int w;
                for (int i = 0; i < 30 && !f_done; i++) begin
                    data_op(1'b1, 1'b0, 32'h80 + 32'h4 * i, 32'h0, 1'b1, d, w);
                end
                @(posedge clk); #1; dm_read_i = 1'b0;
            end
        join
        // Expected grant order with fetch pending throughout: STARVE_MAX data grants, then fetch.
        pat = "DDDDIDDDDI";
        n_tests++;
        if (glog.size() < log0 + 10) begin
            n_fail++; $display("FAIL starve_count: got %0d grants, want >= 10", glog.size() - log0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_tests++;
                if (is_fetch(glog[log0 + i].addr) !== (pat[i] == "I")) begin
                    n_fail++; $display("FAIL starve_order[%0d]: got addr %h, want %s grant",
                                       i, glog[log0 + i].addr, (pat[i] == "I") ? "fetch" : "data");
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        bit got;
        mem_manual = 1'b1; got = 1'b0;
        @(posedge clk); #1;
        dm_read_i = 1'b1; dm_addr_i = 32'h88;
        for (int c = 0; c < 16 && !got; c++) begin
            @(negedge clk);
            if (mem_req_o) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL rst_mid_issue: got no mem_req_o, want one");
        end
        @(posedge clk); #1;
        rst_i = 1'b1; dm_read_i = 1'b0;
        #1;
        n_tests++;
        if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o} !== 4'b0 || mem_addr_o !== 32'h0 ||
            mem_wdata_o !== 32'h0 || if_data_o !== 32'h0 || dm_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_clear: got addr=%h if=%h dm=%h ctl=%b, want all 0",
                               mem_addr_o, if_data_o, dm_rdata_o,
                               {mem_req_o, mem_we_o, if_ack_o, dm_ack_o});
        end
        #2 rst_i = 1'b0;
        @(negedge clk); mem_done_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk); mem_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (dm_ack_o !== 1'b0 || if_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_stale_done[%0d]: got ack=%b%b req=%b, want 000",
                                   i, dm_ack_o, if_ack_o, mem_req_o);
            end
            @(negedge clk);
        end
        mem_manual = 1'b0;
    endtask

    task automatic test_random();
        rand_lat = 1'b1;
        fork
            begin
                logic [31:0] a, d;
                int w, rc, nd;
                bit found;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    a = 32'h4 * $urandom_range(0, 31);
                    fetch_op(a, 1'b0, d, w, rc);
                    n_tests++;
                    if (d !== ref_mem[a[7:2]]) begin
                        n_fail++; $display("FAIL rand_fetch: got %h at %h, want %h",
                                           d, a, ref_mem[a[7:2]]);
                    end
                    nd = 0; found = 1'b0;
                    foreach (glog[j]) begin
                        if (!found && glog[j].cyc > rc) begin
                            if (is_fetch(glog[j].addr)) found = 1'b1;
                            else nd++;
                        end
                    end
                    n_tests++;
                    if (!found || nd > STARVE_MAX) begin
                        n_fail++; $display("FAIL rand_starve: got %0d data grants (found=%b), want <= %0d",
                                           nd, found, STARVE_MAX);
                    end
                end
            end
            begin
                logic [31:0] a, wd, d, last_load;
                int w, op;
                last_load = 32'h0;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    op = $urandom_range(0, 2);
                    a  = 32'h80 + 32'h4 * $urandom_range(0, 31);
                    wd = $urandom;
                    data_op(op != 1, op != 0, a, wd, 1'b0, d, w);
                    n_tests++;
                    if (op == 0) begin
                        if (d !== ref_mem[a[7:2]]) begin
                            n_fail++; $display("FAIL rand_load: got %h at %h, want %h",
                                               d, a, ref_mem[a[7:2]]);
                        end
                        last_load = ref_mem[a[7:2]];
                    end else begin
                        if (d !== last_load) begin
                            n_fail++; $display("FAIL rand_store_rdata: got %h, want %h",
                                               d, last_load);
                        end
                        ref_mem[a[7:2]] = wd;
                    end
                end
            end
        join
        rand_lat = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            phys[i]    = $urandom;
            ref_mem[i] = phys[i];
        end
        test_reset();
        test_fetch();
        test_load_store();
        test_read_write_both();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        test_random();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, want completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
